// File: rtl/addsub_serial_pkg.sv
// Shared ALU definitions for the chunked adder/subtractor: FSM state encoding
// and helpers that size the chunk count and the chunk index register.
package addsub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of CHUNK-wide slices in a WIDTH-wide operand.
  function automatic int unsigned calc_nch(input int unsigned width,
                                           input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  // Chunk index width; never narrower than one bit so NCH = 1 still has a register.
  function automatic int unsigned calc_idx_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/addsub_serial_chunk.sv
// Combinational CHUNK-bit adder slice with carry-in and carry-out.
module addsub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // One slice of the ripple: zero-extend to capture the carry-out bit.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: processes a WIDTH-bit add or subtract CHUNK
// bits per clock, LSB chunk first, with valid/ready handshakes on both sides.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             i_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             overflow
);

  localparam int unsigned NCH   = calc_nch(WIDTH, CHUNK);
  localparam int unsigned IDX_W = calc_idx_w(NCH);

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $fatal(1, "addsub_serial: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               o_carry_q, o_carry_d;
  logic               ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [CHUNK-1:0]   ch_a, ch_b, ch_sum;
  logic               ch_cout;
  logic [WIDTH-1:0]   b_eff;
  int unsigned        base;

  // Operand mux: select the current chunk of both latched operands.
  always_comb begin
    base = (NCH == 1) ? 0 : idx_q * CHUNK;
    ch_a = a_q[base +: CHUNK];
    ch_b = b_q[base +: CHUNK];
  end

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (ch_a),
    .b    (ch_b),
    .cin  (carry_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  // Next-state and datapath update: latch in IDLE, one chunk per RUN cycle, hold in DONE.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    o_carry_d = o_carry_q;
    ovf_d     = ovf_q;
    idx_d     = idx_q;
    b_eff     = sub ? ~b : b;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = i_carry ^ sub;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b_eff[WIDTH-1];
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[base +: CHUNK] = ch_sum;
        carry_d = ch_cout;
        if (idx_q == IDX_W'(NCH - 1)) begin
          o_carry_d = ch_cout;
          // The last chunk's sum MSB is the result MSB.
          ovf_d     = (a_msb_q == b_msb_q) && (ch_sum[CHUNK-1] != a_msb_q);
          state_d   = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      o_carry_q <= 1'b0;
      ovf_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      o_carry_q <= o_carry_d;
      ovf_q     <= ovf_d;
      idx_q     <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign o_result  = res_q;
  assign o_carry   = o_carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench: three builds (CHUNK 8, 32, 4) of a 32-bit addsub_serial,
// directed corner cases on the CHUNK=8 build, then random operations on all.
module tb_addsub_serial;

  localparam int W    = 32;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       [NDUT];
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [W-1:0] a_i       [NDUT];
  logic [W-1:0] b_i       [NDUT];
  logic         sub_i     [NDUT];
  logic         ci_i      [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [W-1:0] o_result  [NDUT];
  logic         o_carry   [NDUT];
  logic         ovf       [NDUT];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    addsub_serial #(
      .WIDTH (W),
      .CHUNK ((g == 0) ? 8 : ((g == 1) ? 32 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a_i[g]),
      .b         (b_i[g]),
      .sub       (sub_i[g]),
      .i_carry   (ci_i[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .o_result  (o_result[g]),
      .o_carry   (o_carry[g]),
      .overflow  (ovf[g])
    );
  end

  function automatic int chunk_of(input int d);
    return (d == 0) ? 8 : ((d == 1) ? 32 : 4);
  endfunction

  // Reference: plain integer arithmetic on the operands; returns {overflow, carry, result}.
  function automatic logic [33:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic c);
    longint unsigned ua, ub, us;
    longint          sa, sb, sr;
    logic [W-1:0]    r;
    logic            cy, v;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (!s) begin
      us = ua + ub + c;
      cy = (us >= 64'h1_0000_0000);
      sr = sa + sb + c;
    end else begin
      us = ua - ub - c;
      cy = (ua >= ub + c);
      sr = sa - sb - c;
    end
    r = us[W-1:0];
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {v, cy, r};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input int d, input string tag);
    chk($sformatf("%s.in_ready", tag),  64'(in_ready[d]),  64'd1);
    chk($sformatf("%s.out_valid", tag), 64'(out_valid[d]), 64'd0);
    chk($sformatf("%s.o_result", tag),  64'(o_result[d]),  64'd0);
    chk($sformatf("%s.o_carry", tag),   64'(o_carry[d]),   64'd0);
    chk($sformatf("%s.overflow", tag),  64'(ovf[d]),       64'd0);
  endtask

  // Present one operand set for one edge; garbage goes back on the bus afterwards.
  task automatic start_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input string tag);
    chk($sformatf("%s.in_ready_pre", tag), 64'(in_ready[d]), 64'd1);
    in_valid[d] = 1'b1;
    a_i[d]      = a;
    b_i[d]      = b;
    sub_i[d]    = s;
    ci_i[d]     = c;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    a_i[d]      = $urandom;
    b_i[d]      = $urandom;
    sub_i[d]    = 1'($urandom);
    ci_i[d]     = 1'($urandom);
  endtask

  // Latency counts the accept edge as 1 and ends at the edge that raises out_valid.
  task automatic wait_done(input int d, input string tag, output int lat);
    lat = 1;
    while (!out_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s.latency", tag), 64'(lat), 64'(W / chunk_of(d) + 1));
  endtask

  task automatic run_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input logic [W-1:0] er,
                        input logic ec, input logic ev, input int hold, input string tag);
    int lat;
    start_op(d, a, b, s, c, tag);
    wait_done(d, tag, lat);
    chk($sformatf("%s.result", tag),   64'(o_result[d]), 64'(er));
    chk($sformatf("%s.carry", tag),    64'(o_carry[d]),  64'(ec));
    chk($sformatf("%s.overflow", tag), 64'(ovf[d]),      64'(ev));
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk($sformatf("%s.in_ready_post", tag),  64'(in_ready[d]),  64'd1);
    chk($sformatf("%s.out_valid_post", tag), 64'(out_valid[d]), 64'd0);
  endtask

  task automatic run_ref(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c, input int hold, input string tag);
    logic [33:0] e;
    e = ref_op(a, b, s, c);
    run_op(d, a, b, s, c, e[31:0], e[32], e[33], hold, tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    logic rs, rc;

    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      a_i[d] = '0; b_i[d] = '0; sub_i[d] = 1'b0; ci_i[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    for (int d = 0; d < NDUT; d++) chk_reset_vals(d, $sformatf("reset%0d", d));

    // Directed corner cases on the CHUNK=8 build.
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, "add_wrap");
    run_op(0, 32'd5, 32'd3, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 0, "sub_5_3");
    run_op(0, 32'd5, 32'd3, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1, "sub_5_3_bin");
    run_op(0, 32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, "sub_ovf");
    run_op(0, 32'd3, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 2, "sub_borrow");
    run_op(0, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 0, "add_ovf");

    // Backpressure: result held for 10 cycles while a new request is waved at it.
    start_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "bp");
    wait_done(0, "bp", lat);
    in_valid[0] = 1'b1;
    a_i[0] = 32'h1234_5678; b_i[0] = 32'h0F0F_0F0F;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d.out_valid", i), 64'(out_valid[0]), 64'd1);
      chk($sformatf("bp%0d.in_ready", i),  64'(in_ready[0]),  64'd0);
      chk($sformatf("bp%0d.result", i),    64'(o_result[0]),  64'h100);
      chk($sformatf("bp%0d.carry", i),     64'(o_carry[0]),   64'd0);
      chk($sformatf("bp%0d.overflow", i),  64'(ovf[0]),       64'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("bp_release.in_ready",  64'(in_ready[0]),  64'd1);
    chk("bp_release.out_valid", 64'(out_valid[0]), 64'd0);
    @(posedge clk); #1;
    chk("bp_idle.in_ready", 64'(in_ready[0]), 64'd1);

    // Reset during the second RUN cycle, then a clean operation.
    start_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "mid_rst");
    @(posedge clk); #1;
    rst[0] = 1'b1;
    #1;
    chk_reset_vals(0, "mid_rst_async");
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk_reset_vals(0, "mid_rst_held");
    run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0, "after_rst");

    // Random operations on every build, biased towards edge operands.
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 300; i++) begin
        ra = pick();
        rb = pick();
        rs = 1'($urandom);
        rc = 1'($urandom);
        run_ref(d, ra, rb, rs, rc, $urandom_range(0, 2), $sformatf("rnd_c%0d_%0d", chunk_of(d), i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
